// File: rtl/bilateral_filter_stream.sv
// bilateral_filter_stream: 3x3 edge-preserving bilateral filter on a stream of windows.
// Weights are spatial (1-2-1 kernel) times a range weight from |p[i]-centre| against a
// runtime-programmable sigma. The weighted sum is normalised by a restoring divider that
// produces one quotient bit per cycle.
// Optional feature macro: BILATERAL_EDGE_FLAG_EN adds out_edge (a neighbour got zero range weight).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
// A producer holds valid and its data stable until that edge; ready may change freely.
// in_ready is high only in IDLE; out_valid is high only in OUTPUT, where out_pixel is stable.
module bilateral_filter_stream #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int SIGMA_DEFAULT = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*PIXEL_WIDTH-1:0] window_flat,
  input  logic                     sigma_load,
  input  logic [PIXEL_WIDTH-1:0]   sigma_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PIXEL_WIDTH-1:0]   out_pixel,
  output logic [2:0]               dbg_state
`ifdef BILATERAL_EDGE_FLAG_EN
  ,
  output logic                     out_edge
`endif
);

  localparam int PW = PIXEL_WIDTH;
  localparam int NW = PW + 6;             // weighted-sum width: 64 * (2^PW - 1) + 32 fits
  localparam int DW = 7;                  // denominator width: holds 16..64
  localparam int CW = $clog2(PW + 1);

  typedef enum logic [2:0] {IDLE, WEIGHT, ACCUM, DIVIDE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [PW-1:0] pix_q [9];
  logic [PW-1:0] sigma_q;
  logic [PW-1:0] sg_work;
  logic [4:0]    w_q [9];
  logic [4:0]    w_c [9];
  logic [NW-1:0] num_c;
  logic [NW-1:0] acc_c;
  logic [DW-1:0] den_c;
  logic [DW-1:0] den_q;
  logic [DW-2:0] rem_q;                   // remainder stays below den, so 6 bits suffice
  logic [PW-1:0] dvd_q;
  logic [PW-1:0] quot_q;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] trial;
  logic [DW-1:0] rem_nxt;
  logic          q_bit;
  logic          last_bit;

  assign dbg_state = state;

  // Range weight from absolute difference to the centre; 2*sg compared at PW+1 bits.
  function automatic logic [2:0] range_w(input logic [PW-1:0] p, input logic [PW-1:0] c,
                                         input logic [PW-1:0] sg);
    logic [PW-1:0] d;
    logic [2:0]    r;
    d = (p >= c) ? (p - c) : (c - p);
    if (d <= (sg >> 1))                r = 3'd4;
    else if (d <= sg)                  r = 3'd2;
    else if ({1'b0, d} <= {sg, 1'b0})  r = 3'd1;
    else                               r = 3'd0;
    return r;
  endfunction

  // Per-tap weight: spatial kernel (corners 1, edges 2, centre 4) times range weight.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      logic [2:0] s;
      s = (i == 4) ? 3'd4 : (((i % 2) == 1) ? 3'd2 : 3'd1);
      w_c[i] = 5'(s) * 5'(range_w(pix_q[i], pix_q[4], sg_work));
    end
  end

  // Weighted sum and weight total from the registered weights, with rounding bias.
  always_comb begin
    num_c = '0;
    den_c = '0;
    for (int i = 0; i < 9; i++) begin
      num_c = num_c + NW'(w_q[i]) * NW'(pix_q[i]);
      den_c = den_c + DW'(w_q[i]);
    end
    acc_c = num_c + NW'(den_c >> 1);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_q, dvd_q[PW-1]};
    q_bit    = (trial >= den_q);
    rem_nxt  = q_bit ? (trial - den_q) : trial;
    last_bit = (bit_cnt == CW'(PW - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = WEIGHT;
      end
      WEIGHT: state_nxt = ACCUM;
      ACCUM:  state_nxt = DIVIDE;
      DIVIDE: if (last_bit) state_nxt = OUTPUT;
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Programmable sigma; loadable at any time, only sampled when a window is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sigma_q <= PW'(SIGMA_DEFAULT);
    else if (sigma_load) sigma_q <= sigma_in;
  end

  // Datapath: capture window, register weights, prepare and run the divider, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        pix_q[i] <= '0;
        w_q[i]   <= '0;
      end
      sg_work   <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quot_q    <= '0;
      bit_cnt   <= '0;
      out_pixel <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < 9; i++) pix_q[i] <= window_flat[i*PW +: PW];
          sg_work <= sigma_q;
        end
        WEIGHT: for (int i = 0; i < 9; i++) w_q[i] <= w_c[i];
        ACCUM: begin
          rem_q   <= acc_c[NW-1:PW];
          dvd_q   <= acc_c[PW-1:0];
          den_q   <= den_c;
          quot_q  <= '0;
          bit_cnt <= '0;
        end
        DIVIDE: begin
          rem_q   <= (DW-1)'(rem_nxt);
          dvd_q   <= dvd_q << 1;
          quot_q  <= PW'({quot_q, q_bit});
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) out_pixel <= PW'({quot_q, q_bit});
        end
        default: ;
      endcase
    end
  end

`ifdef BILATERAL_EDGE_FLAG_EN
  logic edge_q;

  // Edge flag: any neighbour that received zero weight marks a strong edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q   <= 1'b0;
      out_edge <= 1'b0;
    end else begin
      if (state == WEIGHT) begin
        edge_q <= 1'b0;
        for (int i = 0; i < 9; i++)
          if (i != 4 && w_c[i] == 5'd0) edge_q <= 1'b1;
      end
      if (state == DIVIDE && last_bit) out_edge <= edge_q;
    end
  end
`endif

endmodule

// File: tb/tb_bilateral_filter_stream.sv
// Bench for bilateral_filter_stream: directed windows from the filter's behaviour rules,
// then randomized windows and sigmas, checked against an arithmetic reference model.
module tb_bilateral_filter_stream;

  localparam int PW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [9*PW-1:0] window_flat;
  logic            sigma_load;
  logic [PW-1:0]   sigma_in;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_pixel;
  logic [2:0]      dbg_state;
`ifdef BILATERAL_EDGE_FLAG_EN
  logic            out_edge;
`endif

  bilateral_filter_stream #(.PIXEL_WIDTH(PW), .SIGMA_DEFAULT(30)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .window_flat(window_flat),
    .sigma_load(sigma_load),
    .sigma_in(sigma_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .dbg_state(dbg_state)
`ifdef BILATERAL_EDGE_FLAG_EN
    ,
    .out_edge(out_edge)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic          exp_edge_q[$];
  int            cur_p[9];
  int            model_sigma;
  int            s_tab[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: weighted mean of the window with spatial*range weights, rounded.
  function automatic int ref_pixel(input int sg);
    int num = 0;
    int den = 0;
    for (int i = 0; i < 9; i++) begin
      int d, r;
      d = cur_p[i] - cur_p[4];
      if (d < 0) d = -d;
      r = (d <= sg / 2) ? 4 : (d <= sg) ? 2 : (d <= 2 * sg) ? 1 : 0;
      den += s_tab[i] * r;
      num += s_tab[i] * r * cur_p[i];
    end
    return (num + den / 2) / den;
  endfunction

  function automatic logic ref_edge(input int sg);
    logic e = 1'b0;
    for (int i = 0; i < 9; i++) begin
      int d;
      d = cur_p[i] - cur_p[4];
      if (d < 0) d = -d;
      if (i != 4 && d > 2 * sg) e = 1'b1;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_window(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    cur_p = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
  endtask

  // Starts and ends at a negedge; the sigma register takes the value on the edge in between.
  task automatic load_sigma(input int v);
    sigma_load = 1'b1;
    sigma_in   = PW'(v);
    @(negedge clk);
    sigma_load = 1'b0;
    model_sigma = v;
  endtask

  // Presents cur_p at a negedge; acceptance happens on the following posedge.
  task automatic send_window(input string tag);
    for (int i = 0; i < 9; i++) window_flat[i*PW +: PW] = cur_p[i][PW-1:0];
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    exp_q.push_back(PW'(ref_pixel(model_sigma)));
    exp_edge_q.push_back(ref_edge(model_sigma));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result (bounded), checks latency/value, optional backpressure and mid-run sigma load.
  task automatic wait_result(input string tag, input int hold, input bit mid_load, input int mid_val);
    int cyc = 0;
    logic [PW-1:0] expv;
    logic          expe;
    while (out_valid !== 1'b1 && cyc < 64) begin
      if (mid_load && cyc == 5) begin
        sigma_load = 1'b1;
        sigma_in   = PW'(mid_val);
      end
      @(negedge clk);
      sigma_load = 1'b0;
      cyc++;
    end
    if (mid_load) model_sigma = mid_val;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    expe = (exp_edge_q.size() > 0) ? exp_edge_q.pop_front() : 1'b0;
    check({tag, "_latency"}, cyc, PW + 2);
    check({tag, "_pixel"}, out_pixel, expv);
`ifdef BILATERAL_EDGE_FLAG_EN
    check({tag, "_edge"}, out_edge, expe);
`endif
    check({tag, "_in_ready_busy"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_pixel"}, out_pixel, expv);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_pixel_kept"}, out_pixel, expv);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    window_flat = '0;
    sigma_load  = 1'b0;
    sigma_in    = '0;
    out_ready   = 1'b0;
    model_sigma = 30;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_pixel", out_pixel, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform window: result equals the common value.
    set_window(100, 100, 100, 100, 100, 100, 100, 100, 100);
    send_window("uniform");
    wait_result("uniform", 0, 0, 0);
    check("uniform_abs", out_pixel, 100);

    // Small noise: every tap weight 4*s, rounded mean 100.
    set_window(96, 101, 99, 103, 100, 97, 102, 98, 105);
    send_window("noisy");
    wait_result("noisy", 0, 0, 0);
    check("noisy_abs", out_pixel, 100);

    // Sharp edge: the 50s get zero weight.
    set_window(200, 200, 50, 200, 200, 50, 50, 50, 50);
    send_window("sharp");
    wait_result("sharp", 0, 0, 0);
    check("sharp_abs", out_pixel, 200);

    // Weak edge: den=50, num=6080.
    set_window(130, 130, 100, 130, 130, 100, 100, 100, 100);
    send_window("weak");
    wait_result("weak", 0, 0, 0);
    check("weak_abs", out_pixel, 122);

    // Sigma 0 loaded one cycle before acceptance; a load mid-divide must not affect it.
    set_window(50, 50, 50, 50, 200, 50, 50, 50, 50);
    load_sigma(0);
    send_window("sigma0");
    wait_result("sigma0", 0, 1, 255);
    check("sigma0_abs", out_pixel, 200);

    // The mid-divide sigma (255) applies to the next window: sharp window now gives 158.
    set_window(200, 200, 50, 200, 200, 50, 50, 50, 50);
    send_window("sigma255");
    wait_result("sigma255", 0, 0, 0);
    check("sigma255_abs", out_pixel, 158);

    // Backpressure: 20 cycles of out_ready low with in_valid asserted.
    set_window(10, 40, 70, 100, 130, 160, 190, 220, 250);
    send_window("backpressure");
    wait_result("backpressure", 20, 0, 0);

    // Randomized windows and sigmas.
    for (int n = 0; n < 40; n++) begin
      int c, spread;
      if ($urandom_range(0, 1) == 1) load_sigma($urandom_range(0, 90));
      c = $urandom_range(0, 255);
      spread = $urandom_range(0, 3) == 0 ? 255 : 2 * model_sigma + 10;
      for (int i = 0; i < 9; i++) begin
        int v;
        v = c + $urandom_range(0, 2 * spread) - spread;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        cur_p[i] = (i == 4) ? c : v;
      end
      send_window("rand");
      wait_result("rand", $urandom_range(0, 3), 0, 0);
    end

    // Reset mid-divide: aborts with no output, sigma returns to its default.
    load_sigma(255);
    set_window(1, 2, 3, 4, 5, 6, 7, 8, 9);
    send_window("abort");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_pixel", out_pixel, 0);
    exp_q.delete();
    exp_edge_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_sigma = 30;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_output", out_valid, 0);
    end
    set_window(200, 200, 50, 200, 200, 50, 50, 50, 50);
    send_window("post_reset");
    wait_result("post_reset", 0, 0, 0);
    check("post_reset_sigma_default", out_pixel, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
